// File: rtl/regfile_bypass.sv
// regfile_bypass: parametrised register file with write-to-read bypass,
// hardwired zero register, optional registered read data and pending-write scoreboard.
module regfile_bypass #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2,
  parameter bit REG_OUT = 0,
  parameter bit ZERO_REG = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     pend_set,
  input  logic [AW-1:0]            pend_addr,
  output logic [NUM_RD-1:0]        rbusy
);
  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic [NUM_REGS-1:0] pend, pend_n;
  logic [NUM_RD*DATA_W-1:0] rval;
  logic wr;
  // bypass is suppressed while in reset so outputs read as zero
  assign wr = we & ~rst;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '0;
      pend <= '0;
    end else begin
      if (we && !(ZERO_REG && waddr == '0)) mem[waddr] <= wdata;
      pend <= pend_n;
    end
  // set is applied after clear so a new producer wins over a retiring one
  always_comb begin
    pend_n = pend;
    if (we) pend_n[waddr] = 1'b0;
    if (pend_set) pend_n[pend_addr] = 1'b1;
    if (ZERO_REG) pend_n[0] = 1'b0;
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic byp;
    assign ra = raddr[i*AW +: AW];
    assign byp = wr && waddr == ra;
    assign rval[i*DATA_W +: DATA_W] = (ZERO_REG && ra == '0) ? '0 : byp ? wdata : mem[ra];
    assign rbusy[i] = pend[ra] & ~byp;
  end
  if (REG_OUT) begin : g_q
    always_ff @(posedge clk or posedge rst)
      if (rst) rdata <= '0;
      else rdata <= rval;
  end else begin : g_c
    assign rdata = rval;
  end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: checks combinational and registered-output register files against an array model.
module tb_regfile_bypass;
  logic clk = 0, rst = 1, we = 0, pend_set = 0;
  logic [4:0] waddr = 0, pend_addr = 0, ra0 = 0, ra1 = 0;
  logic [31:0] wdata = 0;
  logic [9:0] raddr;
  logic [63:0] rdata_c, rdata_q, exp_q;
  logic [1:0] rbusy_c, rbusy_q;
  logic [31:0] mem_m [32];
  logic pend_m [32];
  int errors = 0, checks = 0;

  assign raddr = {ra1, ra0};
  always #5 clk = ~clk;

  regfile_bypass #(.REG_OUT(0)) dut_c (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_c), .pend_set(pend_set), .pend_addr(pend_addr), .rbusy(rbusy_c));
  regfile_bypass #(.REG_OUT(1)) dut_q (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_q), .pend_set(pend_set), .pend_addr(pend_addr), .rbusy(rbusy_q));

  function automatic logic [31:0] ref_val(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && !rst && waddr == a) return wdata;
    return mem_m[a];
  endfunction
  function automatic logic ref_busy(logic [4:0] a);
    return pend_m[a] && !(we && !rst && waddr == a);
  endfunction
  function automatic logic [63:0] ref_rd();
    return {ref_val(ra1), ref_val(ra0)};
  endfunction
  function automatic logic [1:0] ref_rb();
    return {ref_busy(ra1), ref_busy(ra0)};
  endfunction

  task automatic clear_model();
    foreach (mem_m[i]) begin
      mem_m[i] = 0;
      pend_m[i] = 0;
    end
    exp_q = 0;
  endtask

  task automatic drive(logic w, logic [4:0] wa, logic [31:0] wd, logic ps, logic [4:0] pa,
                       logic [4:0] a0, logic [4:0] a1);
    we = w; waddr = wa; wdata = wd; pend_set = ps; pend_addr = pa; ra0 = a0; ra1 = a1;
  endtask

  // one rising edge; the model follows the same edge
  task automatic tick();
    logic [63:0] nxt;
    nxt = rst ? 64'h0 : ref_rd();
    @(posedge clk);
    if (!rst) begin
      if (we && waddr != 0) mem_m[waddr] = wdata;
      if (we) pend_m[waddr] = 0;
      if (pend_set && pend_addr != 0) pend_m[pend_addr] = 1;
    end
    exp_q = nxt;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 7, 32'hFFFF_FFFF, 1, 7, 7, 7);
    #2;
    checks++;
    if ({rdata_c, rbusy_c, rdata_q, rbusy_q} !== 132'h0) begin
      errors++;
      $display("FAIL reset_hold rdata_c=%h rbusy_c=%b rdata_q=%h rbusy_q=%b exp all 0", rdata_c, rbusy_c, rdata_q, rbusy_q);
    end
    tick(); tick();
    checks++;
    if (rdata_q !== 64'h0) begin
      errors++;
      $display("FAIL reset_edges rdata_q=%h exp 0", rdata_q);
    end
    rst = 0;
    clear_model();
    repeat (40) begin
      drive(1, 5'($urandom), $urandom, 1, 5'($urandom), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1;
    clear_model();
    tick();
    rst = 0;
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      #1;
      checks++;
      if (rdata_c !== 64'h0 || rbusy_c !== 2'b00 || rbusy_q !== 2'b00) begin
        errors++;
        $display("FAIL reset_read a=%0d rdata_c=%h rbusy_c=%b rbusy_q=%b exp 0", a, rdata_c, rbusy_c, rbusy_q);
      end
      tick();
      checks++;
      if (rdata_q !== 64'h0) begin
        errors++;
        $display("FAIL reset_read_q a=%0d rdata_q=%h exp 0", a, rdata_q);
      end
    end
  endtask

  task automatic test_write_readback();
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 9);
    #1;
    checks++;
    if (rdata_c !== {32'h0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL readback_c got=%h exp=%h", rdata_c, {32'h0, 32'hDEAD_BEEF});
    end
    tick();
    checks++;
    if (rdata_q !== {32'h0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL readback_q got=%h exp=%h", rdata_q, {32'h0, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_zero_reg();
    drive(1, 0, 32'h1234_5678, 1, 0, 0, 0);
    #1;
    checks++;
    if ({rdata_c, rbusy_c} !== 66'h0) begin
      errors++;
      $display("FAIL zero_same_cycle rdata=%h rbusy=%b exp 0", rdata_c, rbusy_c);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({rdata_c, rbusy_c, rdata_q} !== 130'h0) begin
      errors++;
      $display("FAIL zero_after rdata_c=%h rbusy=%b rdata_q=%h exp 0", rdata_c, rbusy_c, rdata_q);
    end
  endtask

  task automatic test_bypass();
    drive(1, 7, 32'h1111_1111, 0, 0, 0, 0);
    tick();
    drive(1, 7, 32'hA5A5_A5A5, 0, 0, 7, 8);
    #1;
    checks++;
    if (rdata_c !== {32'h0, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL bypass_c got=%h exp=%h", rdata_c, {32'h0, 32'hA5A5_A5A5});
    end
    checks++;
    if (rdata_q !== 64'h0) begin
      errors++;
      $display("FAIL bypass_q_early got=%h exp 0", rdata_q);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (rdata_q !== {32'h0, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL bypass_q got=%h exp=%h", rdata_q, {32'h0, 32'hA5A5_A5A5});
    end
  endtask

  task automatic test_scoreboard();
    drive(0, 0, 0, 1, 3, 3, 3);
    tick();
    drive(0, 0, 0, 0, 0, 3, 3);
    #1;
    checks++;
    if (rbusy_c !== 2'b11 || rbusy_q !== 2'b11) begin
      errors++;
      $display("FAIL pend_set rbusy_c=%b rbusy_q=%b exp 11", rbusy_c, rbusy_q);
    end
    tick();
    drive(1, 3, 32'h55, 0, 0, 3, 3);
    #1;
    checks++;
    if (rbusy_c !== 2'b00 || rdata_c !== {32'h55, 32'h55}) begin
      errors++;
      $display("FAIL pend_retire rbusy=%b rdata=%h exp 00 %h", rbusy_c, rdata_c, {32'h55, 32'h55});
    end
    tick();
    drive(0, 0, 0, 0, 0, 3, 3);
    #1;
    checks++;
    if (rbusy_c !== 2'b00 || rdata_c !== {32'h55, 32'h55}) begin
      errors++;
      $display("FAIL pend_cleared rbusy=%b rdata=%h exp 00 %h", rbusy_c, rdata_c, {32'h55, 32'h55});
    end
    drive(1, 3, 32'h66, 1, 3, 3, 3);
    #1;
    checks++;
    if (rbusy_c !== 2'b00) begin
      errors++;
      $display("FAIL pend_both_same rbusy=%b exp 00", rbusy_c);
    end
    tick();
    drive(0, 0, 0, 0, 0, 3, 3);
    #1;
    checks++;
    if (rbusy_c !== 2'b11 || rdata_c !== {32'h66, 32'h66}) begin
      errors++;
      $display("FAIL pend_set_wins rbusy=%b rdata=%h exp 11 %h", rbusy_c, rdata_c, {32'h66, 32'h66});
    end
    drive(1, 3, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    v = $urandom | 32'h1;
    drive(1, 10, v, 1, 10, 10, 10);
    tick();
    drive(0, 0, 0, 0, 0, 10, 10);
    #1;
    checks++;
    if (rbusy_c !== 2'b11 || rdata_c !== {v, v}) begin
      errors++;
      $display("FAIL arst_pre rbusy=%b rdata=%h exp 11 %h", rbusy_c, rdata_c, {v, v});
    end
    tick();
    #2;
    rst = 1;
    clear_model();
    #1;
    checks++;
    if ({rdata_c, rbusy_c, rdata_q, rbusy_q} !== 132'h0) begin
      errors++;
      $display("FAIL arst_immediate rdata_c=%h rbusy_c=%b rdata_q=%h rbusy_q=%b exp 0", rdata_c, rbusy_c, rdata_q, rbusy_q);
    end
    drive(1, 10, 32'hFFFF_0000, 1, 10, 10, 10);
    tick();
    drive(0, 0, 0, 0, 0, 10, 10);
    rst = 0;
    #1;
    checks++;
    if ({rdata_c, rbusy_c, rdata_q} !== 130'h0) begin
      errors++;
      $display("FAIL arst_after rdata_c=%h rbusy=%b rdata_q=%h exp 0", rdata_c, rbusy_c, rdata_q);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom), 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'(n % 5 == 0 ? $urandom : $urandom_range(0, 7)));
      #1;
      checks++;
      if (rdata_c !== ref_rd() || rbusy_c !== ref_rb() || rbusy_q !== ref_rb()) begin
        errors++;
        $display("FAIL rand_comb n=%0d rdata=%h/%h rbusy=%b,%b/%b", n, rdata_c, ref_rd(), rbusy_c, rbusy_q, ref_rb());
      end
      checks++;
      if (rdata_q !== exp_q) begin
        errors++;
        $display("FAIL rand_q n=%0d rdata_q=%h exp=%h", n, rdata_q, exp_q);
      end
      tick();
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_write_readback();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
